// File: rtl/counter_cmd_arbiter_if.sv
// Requester-side and counter-side signal bundle for counter_cmd_arbiter.
// The arbiter takes the slave modport; the requesters and the counter take the master modport.
interface counter_cmd_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CNT_WIDTH = 5,
  parameter int unsigned STEP_W    = 3
);
  logic [NUM_REQ-1:0]           REQ;
  logic [2*NUM_REQ-1:0]         CMD;
  logic [CNT_WIDTH*NUM_REQ-1:0] DATA;
  logic [STEP_W*NUM_REQ-1:0]    STEPS;
  logic [NUM_REQ-1:0]           ACK;
  logic                         SAT;
  logic [2:0]                   GNT_ID;
  logic                         BUSY;
  logic [CNT_WIDTH-1:0]         IN;
  logic                         LOAD;
  logic                         UP;
  logic                         DOWN;
  logic                         FLAG_High;
  logic                         FLAG_LOW;

  modport slave (
    input  REQ, CMD, DATA, STEPS, FLAG_High, FLAG_LOW,
    output ACK, SAT, GNT_ID, BUSY, IN, LOAD, UP, DOWN
  );

  modport master (
    output REQ, CMD, DATA, STEPS, FLAG_High, FLAG_LOW,
    input  ACK, SAT, GNT_ID, BUSY, IN, LOAD, UP, DOWN
  );
endinterface

// File: rtl/counter_cmd_arbiter.sv
// Round-robin arbiter that turns per-requester burst commands into single-cycle
// LOAD/UP/DOWN strobes for a shared saturating counter, stopping bursts at saturation.
module counter_cmd_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CNT_WIDTH = 5,
  parameter int unsigned STEP_W    = 3
) (
  input logic                  CLK,
  input logic                  RST,
  counter_cmd_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  localparam logic [1:0]         CmdNop  = 2'b00;
  localparam logic [1:0]         CmdUp   = 2'b01;
  localparam logic [1:0]         CmdDown = 2'b10;
  localparam logic [1:0]         CmdLoad = 2'b11;
  localparam logic [NUM_REQ-1:0] ReqOne  = NUM_REQ'(1);
  localparam logic [STEP_W:0]    RemOne  = (STEP_W+1)'(1);

  state_e               state_q, state_d;
  logic [1:0]           cmd_q, cmd_d;
  logic [CNT_WIDTH-1:0] data_q, data_d;
  logic [STEP_W:0]      rem_q, rem_d;
  logic [2:0]           gnt_q, gnt_d;
  logic [2:0]           ptr_q, ptr_d;
  logic                 sat_q, sat_d;

  logic                 win_vld;
  logic [2:0]           win_idx;
  logic [31:0]          cand;
  logic [1:0]           win_cmd;
  logic [CNT_WIDTH-1:0] win_data;
  logic [STEP_W-1:0]    win_steps;
  logic                 sat_hit;

  // First set REQ bit searching upward from ptr_q+1, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(ptr_q) + i) % NUM_REQ;
      if (!win_vld && ((bus.REQ & (ReqOne << cand)) != '0)) begin
        win_vld = 1'b1;
        win_idx = 3'(cand);
      end
    end
  end

  assign win_cmd   = 2'(bus.CMD >> (32'(win_idx) * 2));
  assign win_data  = CNT_WIDTH'(bus.DATA >> (32'(win_idx) * CNT_WIDTH));
  assign win_steps = STEP_W'(bus.STEPS >> (32'(win_idx) * STEP_W));

  // Flags reflect the counter after the previous strobe, so they gate this cycle's strobe.
  assign sat_hit = ((cmd_q == CmdUp) && bus.FLAG_High) || ((cmd_q == CmdDown) && bus.FLAG_LOW);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    rem_d   = rem_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        if (win_vld) begin
          gnt_d   = win_idx;
          cmd_d   = win_cmd;
          data_d  = (win_cmd == CmdLoad) ? win_data : data_q;
          rem_d   = (win_cmd == CmdLoad) ? RemOne : {1'b0, win_steps} + RemOne;
          state_d = (win_cmd == CmdNop) ? StResp : StIssue;
        end
      end
      StIssue: begin
        if (sat_hit) begin
          sat_d   = 1'b1;
          state_d = StResp;
        end else begin
          rem_d = rem_q - RemOne;
          if (rem_q == RemOne) state_d = StResp;
        end
      end
      StResp: begin
        ptr_d   = gnt_q;
        sat_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      cmd_q   <= CmdNop;
      data_q  <= '0;
      rem_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= 3'(NUM_REQ - 1);
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.LOAD   = (state_q == StIssue) && (cmd_q == CmdLoad);
  assign bus.UP     = (state_q == StIssue) && (cmd_q == CmdUp) && !bus.FLAG_High;
  assign bus.DOWN   = (state_q == StIssue) && (cmd_q == CmdDown) && !bus.FLAG_LOW;
  assign bus.IN     = data_q;
  assign bus.ACK    = (state_q == StResp) ? (ReqOne << gnt_q) : '0;
  assign bus.SAT    = sat_q;
  assign bus.BUSY   = (state_q != StIdle);
  assign bus.GNT_ID = gnt_q;

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Directed bench for counter_cmd_arbiter with a behavioural 5-bit saturating counter
// behind it; single-request vectors from a table plus round-robin and reset sequences.
module tb_counter_cmd_arbiter;
  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned CNT_WIDTH = 5;
  localparam int unsigned STEP_W    = 3;
  localparam logic [NUM_REQ-1:0] ReqOne = NUM_REQ'(1);

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  counter_cmd_arbiter_if #(.NUM_REQ(NUM_REQ), .CNT_WIDTH(CNT_WIDTH), .STEP_W(STEP_W)) bus ();

  counter_cmd_arbiter #(.NUM_REQ(NUM_REQ), .CNT_WIDTH(CNT_WIDTH), .STEP_W(STEP_W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // Shared counter: not reset by RST, saturating at both ends.
  logic [4:0] cnt = 5'd0;
  always @(posedge CLK) begin
    if (bus.LOAD) cnt <= bus.IN;
    else if (bus.UP && cnt != 5'd31) cnt <= cnt + 5'd1;
    else if (bus.DOWN && cnt != 5'd0) cnt <= cnt - 5'd1;
  end
  assign bus.FLAG_High = (cnt == 5'd31);
  assign bus.FLAG_LOW  = (cnt == 5'd0);

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         id;
    logic [1:0] cmd;
    logic [4:0] data;
    logic [2:0] steps;
    int         ups;
    int         downs;
    int         loads;
    int         sat;
    int         cnt;
    int         lat;    // cycles from the REQ-sampling edge to the ACK cycle
  } vec_t;

  vec_t vecs[10];

  // One request, counted strobes until ACK, then one IDLE cycle of post-checks.
  task automatic run_txn(input vec_t v, input int k);
    int lat, ups, downs, loads, multi, bad_busy, bad_in;
    bit done;
    bus.REQ   = ReqOne << v.id;
    bus.CMD   = (2*NUM_REQ)'(v.cmd) << (2*v.id);
    bus.DATA  = (CNT_WIDTH*NUM_REQ)'(v.data) << (CNT_WIDTH*v.id);
    bus.STEPS = (STEP_W*NUM_REQ)'(v.steps) << (STEP_W*v.id);
    lat = 0; ups = 0; downs = 0; loads = 0; multi = 0; bad_busy = 0; bad_in = 0; done = 0;
    while (!done && lat < 20) begin
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        bus.CMD   = ~bus.CMD;
        bus.DATA  = ~bus.DATA;
        bus.STEPS = ~bus.STEPS;
      end
      ups   += int'(bus.UP);
      downs += int'(bus.DOWN);
      loads += int'(bus.LOAD);
      if (int'(bus.UP) + int'(bus.DOWN) + int'(bus.LOAD) > 1) multi++;
      if (bus.LOAD && bus.IN != v.data) bad_in++;
      if (!bus.BUSY || int'(bus.GNT_ID) != v.id) bad_busy++;
      if (bus.ACK != '0) begin
        done = 1;
        check($sformatf("v%0d_ack", k), int'(bus.ACK), int'(ReqOne << v.id));
        check($sformatf("v%0d_sat", k), int'(bus.SAT), v.sat);
        bus.REQ = bus.REQ & ~bus.ACK;
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL v%0d_timeout: got no ACK, expected ACK within 20 cycles", k);
    end
    check($sformatf("v%0d_lat", k), lat, v.lat);
    check($sformatf("v%0d_ups", k), ups, v.ups);
    check($sformatf("v%0d_downs", k), downs, v.downs);
    check($sformatf("v%0d_loads", k), loads, v.loads);
    check($sformatf("v%0d_onehot", k), multi, 0);
    check($sformatf("v%0d_busy_gnt", k), bad_busy, 0);
    check($sformatf("v%0d_in", k), bad_in, 0);
    @(negedge CLK);
    check($sformatf("v%0d_idle", k),
          int'({bus.BUSY, bus.SAT, bus.LOAD, bus.UP, bus.DOWN, |bus.ACK}), 0);
    check($sformatf("v%0d_cnt", k), int'(cnt), v.cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int order[$];
    int ack_cyc[$];
    bit raised;
    bit got;
    int exp_order[6];

    //           id cmd    data   steps ups dn ld sat cnt lat
    vecs[0] = '{0, 2'b11, 5'd17, 3'd0, 0, 0, 1, 0, 17, 2};
    vecs[1] = '{1, 2'b11, 5'd10, 3'd0, 0, 0, 1, 0, 10, 2};
    vecs[2] = '{1, 2'b01, 5'd0,  3'd3, 4, 0, 0, 0, 14, 5};
    vecs[3] = '{2, 2'b11, 5'd28, 3'd0, 0, 0, 1, 0, 28, 2};
    vecs[4] = '{2, 2'b01, 5'd0,  3'd7, 3, 0, 0, 1, 31, 5};
    vecs[5] = '{2, 2'b11, 5'd2,  3'd0, 0, 0, 1, 0, 2,  2};
    vecs[6] = '{2, 2'b10, 5'd0,  3'd7, 0, 2, 0, 1, 0,  4};
    vecs[7] = '{3, 2'b00, 5'd9,  3'd5, 0, 0, 0, 0, 0,  1};
    vecs[8] = '{3, 2'b10, 5'd0,  3'd0, 0, 0, 0, 1, 0,  2};
    vecs[9] = '{0, 2'b01, 5'd0,  3'd7, 8, 0, 0, 0, 8,  9};

    bus.REQ = '0; bus.CMD = '0; bus.DATA = '0; bus.STEPS = '0;
    RST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("reset_ctrl",
          int'({bus.ACK, bus.SAT, bus.LOAD, bus.UP, bus.DOWN, bus.BUSY}), 0);
    check("reset_in", int'(bus.IN), 0);
    check("reset_gnt", int'(bus.GNT_ID), 0);
    RST = 1'b1;
    @(negedge CLK);

    for (int k = 0; k < 10; k++) run_txn(vecs[k], k);

    // Round robin from the reset pointer; REQ0/REQ2 re-raised during REQ3's burst.
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    bus.REQ   = 4'b1111;
    bus.CMD   = 8'b01_01_01_01;
    bus.STEPS = '0;
    bus.DATA  = '0;
    raised = 0;
    for (int c = 1; c <= 40 && order.size() < 6; c++) begin
      @(negedge CLK);
      if (!raised && bus.BUSY && bus.GNT_ID == 3'd3 && bus.UP) begin
        bus.REQ = bus.REQ | 4'b0101;
        raised = 1;
      end
      if (bus.ACK != '0) begin
        order.push_back($clog2(bus.ACK));
        ack_cyc.push_back(c);
        bus.REQ = bus.REQ & ~bus.ACK;
      end
    end
    check("rr_count", order.size(), 6);
    exp_order = '{0, 1, 2, 3, 0, 2};
    for (int i = 0; i < 6 && i < order.size(); i++)
      check($sformatf("rr_grant%0d", i), order[i], exp_order[i]);
    for (int i = 0; i + 1 < ack_cyc.size(); i++)
      check($sformatf("rr_gap%0d", i), ack_cyc[i+1] - ack_cyc[i], 3);
    @(negedge CLK);
    check("rr_cnt", int'(cnt), 14);

    // Reset during the second step of a 6-step down burst.
    bus.REQ   = 4'b0010;
    bus.CMD   = 8'b10_00_10_00;
    bus.STEPS = {3'd5, 3'd0, 3'd5, 3'd0};
    @(negedge CLK);
    check("abort_step1", int'(bus.DOWN), 1);
    @(negedge CLK);
    check("abort_step2", int'(bus.DOWN), 1);
    RST = 1'b0;
    #1;
    check("abort_strobes", int'({bus.LOAD, bus.UP, bus.DOWN}), 0);
    check("abort_busy", int'(bus.BUSY), 0);
    check("abort_ack", int'(bus.ACK), 0);
    bus.REQ = 4'b1010;
    @(negedge CLK);
    RST = 1'b1;
    got = 0;
    for (int c = 0; c < 5 && !got; c++) begin
      @(negedge CLK);
      check($sformatf("abort_noack%0d", c), int'(bus.ACK), 0);
      if (bus.BUSY) begin
        got = 1;
        check("abort_regrant", int'(bus.GNT_ID), 1);
      end
    end
    check("abort_granted", int'(got), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
